dmem_bus_bridge: RTL
====================

// Module: dmem_bus_bridge
// PURPOSE
// - Downstream of the CPU data-memory port: converts single-cycle load/store strobes into req/ack transactions on an external memory bus.
// - Stores are posted into a WBUF_DEPTH-entry write buffer. Loads stall the CPU until the bus returns data.
// - Loads are strictly ordered behind all buffered stores. A per-transaction timeout prevents a dead bus from hanging the core.
// PARAMETERS
// - ADDR_W      32   byte address width
// - DATA_W      32   data width
// - WBUF_DEPTH  2    posted-write buffer entries; power of 2, >=2
// - TIMEOUT     255  cycles a bus_req may wait for bus_ack before it is aborted
// PORTS
// - clk          in   1       single clock; all state on posedge
// - rst_n        in   1       asynchronous, active-low reset
// - cpu_MemRead  in   1       load strobe; held by CPU while cpu_stall=1
// - cpu_MemWrite in   1       store strobe; held by CPU while cpu_stall=1
// - cpu_addr     in   ADDR_W  ALU result (load/store address)
// - cpu_wdata    in   DATA_W  store data (rt register)
// - cpu_rdata    out  DATA_W  load data; registered
// - cpu_stall    out  1       freeze PC/regfile this cycle
// - bus_req      out  1       transaction request; registered
// - bus_we       out  1       1=write, 0=read
// - bus_addr     out  ADDR_W  held stable while bus_req=1
// - bus_wdata    out  DATA_W  held stable while bus_req=1
// - bus_ack      in   1       completes the current request in the cycle it is sampled high with bus_req
// - bus_rdata    in   DATA_W  valid in the ack cycle of a read
// - err_timeout  out  1       sticky; set on any timeout, cleared only by reset
// BEHAVIOUR
// - Reset (async, immediate):
//   - state=IDLE; FIFO empty; timeout counter=0.
//   - bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, cpu_rdata=0, err_timeout=0.
//   - Reset mid-transaction drops bus_req at once and discards pending writes.
// - FSM states:
//   - IDLE: bus idle.
//     - FIFO non-empty -> WDRAIN.
//     - Else cpu_MemRead -> RD_WAIT.
//   - WDRAIN: bus_req=1, bus_we=1, addr/data = FIFO head.
//     - On ack: pop head.
//     - Next state: WDRAIN if more entries remain, else IDLE. The read is issued from IDLE the following cycle.
//   - RD_WAIT: bus_req=1, bus_we=0, addr=cpu_addr (latched).
//     - On ack: cpu_rdata<=bus_rdata -> RD_DONE.
//   - RD_DONE: cpu_stall=0 for exactly one cycle so the CPU commits the load -> IDLE.
//     - cpu_MemRead still high in this cycle is NOT reissued.
// - Handshake:
//   - bus_req, bus_addr, bus_wdata and bus_we are stable from assertion until the ack cycle.
//   - The next request is driven no earlier than the cycle after an ack. There is no back-to-back ack pipelining.
// - Stores:
//   - Enqueued at posedge when cpu_MemWrite=1 and the FIFO is not full; no stall.
//   - cpu_stall = cpu_MemWrite & full. Full is from the registered count; an ack in the same cycle does not bypass the stall.
//   - Enqueue and pop may occur in the same cycle (count unchanged). Pointers wrap modulo WBUF_DEPTH.
// - Loads:
//   - cpu_stall = cpu_MemRead in every state except RD_DONE.
//   - Minimum load latency: issue cycle + 1 bus cycle = 2 stall cycles when the FIFO is empty and bus_ack is high in the first req cycle.
// - Simultaneous cpu_MemRead & cpu_MemWrite: treated as a load only; the store is dropped.
// - Timeout:
//   - Counter resets on every new request and increments while bus_req=1 and bus_ack=0.
//   - When it reaches TIMEOUT: drop bus_req and set err_timeout.
//   - Write timeout: pop the entry.
//   - Read timeout: cpu_rdata<=32'hDEADBEEF -> RD_DONE.
// - bus_ack while bus_req=0: ignored.
// STRUCTURE
// - Shared header dmem_bridge_defs.vh:
//   - state encodings S_IDLE=2'd0, S_WDRAIN=2'd1, S_RD_WAIT=2'd2, S_RD_DONE=2'd3
//   - RD_ERR_DATA=32'hDEADBEEF
// - Sub-module dmem_wbuf_fifo (DEPTH, width ADDR_W+DATA_W):
//   - ports push, pop, din, dout, full, empty
//   - async active-low reset
// - Top level: FSM, timeout counter, output registers, stall logic.
// TESTING
// - Load, FIFO empty, bus_ack=1 at first req cycle, bus_rdata=32'h1234_5678:
//   - cpu_stall=1 for 2 cycles.
//   - cpu_rdata=32'h12345678 in RD_DONE.
//   - Exactly one bus read at cpu_addr.
// - 3 back-to-back stores (A0/D0..A2/D2), bus_ack held 0 for 10 cycles:
//   - First two stores accepted without stall; third stalls until the first ack.
//   - Bus writes appear in order A0, A1, A2.
// - Store to 0x10 (data 0xAA) buffered, then load from 0x10:
//   - Bus shows write 0x10 before read 0x10.
//   - Load returns the bus value; cpu_stall held throughout the drain.
// - Read with bus_ack stuck 0:
//   - bus_req drops after 255 cycles.
//   - err_timeout=1 and stays 1.
//   - cpu_rdata=32'hDEADBEEF; CPU released.
// - rst_n pulsed low while in RD_WAIT with 2 buffered writes:
//   - bus_req=0 asynchronously; FIFO empty; all outputs at reset values.
//   - No write is issued after release.
// - cpu_MemRead=cpu_MemWrite=1 in the same cycle:
//   - Only a bus read is issued; FIFO count unchanged.

Source files
------------

// File: rtl/dmem_bus_bridge_pkg.sv
// dmem_bus_bridge_pkg: shared state encoding and read-error pattern for the data-memory bus bridge
package dmem_bus_bridge_pkg;
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WDRAIN  = 2'd1,
    S_RD_WAIT = 2'd2,
    S_RD_DONE = 2'd3
  } state_t;
  localparam logic [31:0] RD_ERR_DATA = 32'hDEADBEEF;
endpackage

// File: rtl/dmem_wbuf_fifo.sv
// dmem_wbuf_fifo: posted-write buffer holding {addr, data} entries in store order
module dmem_wbuf_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic         last
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp, lvl;
  // extra pointer bit separates full from empty
  assign lvl   = wp - rp;
  assign full  = lvl == (AW+1)'(DEPTH);
  assign empty = lvl == '0;
  assign last  = lvl == (AW+1)'(1);
  assign dout  = mem[rp[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
    end
  always_ff @(posedge clk)
    if (push) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/dmem_bus_bridge.sv
// dmem_bus_bridge: CPU load/store strobes to req/ack bus with posted writes, ordered loads and timeout
module dmem_bus_bridge
  import dmem_bus_bridge_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int WBUF_DEPTH = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_MemRead,
  input  logic              cpu_MemWrite,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              err_timeout
);
  localparam int TW = $clog2(TIMEOUT + 1);
  state_t state, state_nx;
  logic full, empty, last, push, ack, tmo, done, issue_w, issue_r;
  logic [ADDR_W+DATA_W-1:0] head;
  logic [TW-1:0] tcnt;
  assign push = cpu_MemWrite & ~cpu_MemRead & ~full;
  assign ack  = bus_req & bus_ack;
  assign tmo  = bus_req & ~bus_ack & (tcnt == TW'(TIMEOUT - 1));
  assign done = ack | tmo;
  // a simultaneous load/store is a load, so the store never stalls it
  assign cpu_stall = (cpu_MemRead & (state != S_RD_DONE)) | (cpu_MemWrite & ~cpu_MemRead & full);
  dmem_wbuf_fifo #(.DEPTH(WBUF_DEPTH), .W(ADDR_W + DATA_W)) u_wbuf (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .pop  ((state == S_WDRAIN) & done),
    .din  ({cpu_addr, cpu_wdata}),
    .dout (head),
    .full (full),
    .empty(empty),
    .last (last)
  );
  // WDRAIN with bus_req low is the gap cycle between consecutive writes
  always_comb begin
    issue_w  = ~empty & ((state == S_IDLE) | ((state == S_WDRAIN) & ~bus_req));
    issue_r  = empty & cpu_MemRead & (state == S_IDLE);
    state_nx = issue_w ? S_WDRAIN
             : issue_r ? S_RD_WAIT
             : (state == S_RD_DONE) ? S_IDLE
             : ((state == S_RD_WAIT) & done) ? S_RD_DONE
             : ((state == S_WDRAIN) & done & last & ~push) ? S_IDLE
             : ((state == S_WDRAIN) & ~bus_req) ? S_IDLE
             : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= S_IDLE;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= '0;
      bus_wdata   <= '0;
      cpu_rdata   <= '0;
      err_timeout <= 1'b0;
      tcnt        <= '0;
    end else begin
      state <= state_nx;
      if (issue_w | issue_r) begin
        bus_req  <= 1'b1;
        bus_we   <= issue_w;
        bus_addr <= issue_w ? head[ADDR_W+DATA_W-1:DATA_W] : cpu_addr;
        tcnt     <= '0;
      end else if (done) bus_req <= 1'b0;
      else if (bus_req) tcnt <= tcnt + 1'b1;
      if (issue_w) bus_wdata <= head[DATA_W-1:0];
      if (tmo) err_timeout <= 1'b1;
      if (state == S_RD_WAIT & ack) cpu_rdata <= bus_rdata;
      else if (state == S_RD_WAIT & tmo) cpu_rdata <= DATA_W'(RD_ERR_DATA);
    end
endmodule
